alarm_ctrl: RTL and testbench
=============================

ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have parameter RING_SECS, default 60, ring duration before auto-timeout, in seconds.
REQ-002 SHALL have parameter SNOOZE_SECS, default 300, snooze delay before re-ring, in seconds.
REQ-003 SHALL have parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; ports: clk  in  1  system clock; reset  in  1  async active-high reset.
REQ-005 SHALL have tick_1hz  in  1  one-clk-wide pulse once per second, synchronous to clk.
REQ-006 SHALL have Sec_in, Min_in, Hour_in  in  7 each  current clock time, binary.
REQ-007 SHALL have Sec_alm, Min_alm, Hour_alm  in  7 each  programmed alarm time, binary.
REQ-008 SHALL have alarm_en  in  1  level; 0 disarms the alarm.
REQ-009 SHALL have stop  in  1  one-clk pulse; ends the alarm event.
REQ-010 SHALL have snooze  in  1  one-clk pulse; defers ringing.
REQ-011 SHALL have music_out  out  1  buzzer enable.
REQ-012 SHALL have state  out  2  current FSM state code.
REQ-013 SHALL have snooze_cnt  out  2  snoozes used in the current event.

Function
REQ-014 SHALL implement FSM states IDLE=0, ARMED=1, RINGING=2, SNOOZE=3.
- IDLE->ARMED: alarm_en=1.
- Any state->IDLE: alarm_en=0, which has highest priority after reset.
REQ-015 SHALL define match as registered (Sec_in==Sec_alm && Min_in==Min_alm && Hour_in==Hour_alm), evaluated only on tick_1hz cycles.
- Only a rising edge of match triggers.
- A match held for many ticks triggers once.
REQ-016 SHALL go ARMED->RINGING on the cycle after a triggering match edge.
- On entry: ring timer=RING_SECS, snooze_cnt=0.
REQ-017 SHALL, in RINGING, drive music_out as 1-s-on/1-s-off.
- music_out=1 on the first cycle of RINGING.
- music_out toggles on each tick_1hz.
- music_out=0 in every other state.
REQ-018 SHALL decrement the ring timer on each tick_1hz in RINGING; at 0, go to ARMED (timeout).
REQ-019 SHALL, when stop=1 in RINGING or SNOOZE, go to ARMED next cycle and clear snooze_cnt.
REQ-020 SHALL, when snooze=1 in RINGING and snooze_cnt<MAX_SNOOZE, go to SNOOZE.
- snooze_cnt increments.
- snooze timer=SNOOZE_SECS.
REQ-021 SHALL ignore snooze when snooze_cnt==MAX_SNOOZE; ringing continues.
REQ-022 SHALL decrement the snooze timer on each tick_1hz in SNOOZE.
- At 0: go to RINGING and reload the ring timer.
- snooze_cnt is retained.
REQ-023 SHALL resolve stop and snooze asserted in the same cycle as stop.
REQ-024 SHALL ignore match edges while in RINGING or SNOOZE.
REQ-025 SHALL size timers to clog2(max(RING_SECS,SNOOZE_SECS)+1) bits, unsigned, with no wrap below 0.
REQ-026 SHALL let a tick coinciding with stop or snooze affect only the next state; the timer decrement is discarded.

Reset
REQ-027 SHALL, while reset=1, force state=IDLE, music_out=0, snooze_cnt=0, timers=0, and match register=0.
REQ-028 SHALL abort ringing immediately on reset mid-event; a match still present after reset release SHALL NOT trigger until it deasserts and reasserts.

Structure
REQ-029 SHALL take state encodings and default RING_SECS/SNOOZE_SECS/MAX_SNOOZE from shared package clock_pkg.
REQ-030 SHALL instantiate one sub-module, sec_timer (loadable 1-Hz down-counter with zero flag), shared by the ring and snooze timing.

Verification
REQ-031 SHALL cover: alarm 07:30:00, alarm_en=1, time advances 07:29:59->07:30:00 -> RINGING next cycle, music_out=1, then toggling per tick.
REQ-032 SHALL cover: ringing with no input -> ARMED after 60 ticks, music_out=0.
REQ-033 SHALL cover: snooze pulsed 4 times across re-rings -> snooze_cnt reaches 3, 4th ignored, re-ring occurs 300 ticks after each snooze.
REQ-034 SHALL cover: stop and snooze in the same cycle while RINGING -> ARMED, snooze_cnt=0.
REQ-035 SHALL cover: reset pulsed mid-SNOOZE while time still equals alarm -> IDLE, no re-trigger on following ticks.
REQ-036 SHALL cover: alarm_en dropped during RINGING -> IDLE next cycle, music_out=0.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared alarm-clock definitions: FSM encoding, default timing parameters,
// time-of-day payload and timer sizing helper.
package clock_pkg;

  localparam int unsigned TIME_W          = 7;
  localparam int unsigned RING_SECS_DEF   = 60;
  localparam int unsigned SNOOZE_SECS_DEF = 300;
  localparam int unsigned MAX_SNOOZE_DEF  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_e;

  typedef struct packed {
    logic [TIME_W-1:0] hour;
    logic [TIME_W-1:0] min;
    logic [TIME_W-1:0] sec;
  } hms_t;

  // Bits needed to hold the longer of the two countdowns
  function automatic int unsigned timer_width(input int unsigned ring_secs,
                                              input int unsigned snooze_secs);
    int unsigned max_secs;
    max_secs = (ring_secs > snooze_secs) ? ring_secs : snooze_secs;
    return (max_secs == 0) ? 32'd1 : $clog2(max_secs + 32'd1);
  endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// Alarm controller signal bundle: time inputs, user controls and buzzer/status.
interface alarm_ctrl_if;
  import clock_pkg::*;

  logic              tick_1hz;
  logic [TIME_W-1:0] Sec_in;
  logic [TIME_W-1:0] Min_in;
  logic [TIME_W-1:0] Hour_in;
  logic [TIME_W-1:0] Sec_alm;
  logic [TIME_W-1:0] Min_alm;
  logic [TIME_W-1:0] Hour_alm;
  logic              alarm_en;
  logic              stop;
  logic              snooze;
  logic              music_out;
  logic [1:0]        state;
  logic [1:0]        snooze_cnt;

  modport slave (
    input  tick_1hz, Sec_in, Min_in, Hour_in, Sec_alm, Min_alm, Hour_alm,
           alarm_en, stop, snooze,
    output music_out, state, snooze_cnt
  );

  modport master (
    output tick_1hz, Sec_in, Min_in, Hour_in, Sec_alm, Min_alm, Hour_alm,
           alarm_en, stop, snooze,
    input  music_out, state, snooze_cnt
  );
endinterface

// File: rtl/sec_timer.sv
// Loadable seconds down-counter; saturates at zero and flags it.
module sec_timer #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load has priority so a tick landing on a reload is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: arms on enable, rings on a fresh time match, supports
// a limited number of snoozes and times out back to armed.
module alarm_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned RING_SECS   = RING_SECS_DEF,
  parameter int unsigned SNOOZE_SECS = SNOOZE_SECS_DEF,
  parameter int unsigned MAX_SNOOZE  = MAX_SNOOZE_DEF
) (
  input  logic         clk,
  input  logic         reset,
  alarm_ctrl_if.slave  bus
);

  localparam int unsigned TW = timer_width(RING_SECS, SNOOZE_SECS);
  localparam int unsigned CW = 2;

  alarm_state_e  r_state, w_state_nxt;
  logic          r_music, w_music_nxt;
  logic [CW-1:0] r_snz_cnt, w_snz_cnt_nxt;
  logic          r_match;
  logic          r_low_seen;
  hms_t          w_now, w_alm;
  logic          w_eq, w_trigger, w_last;
  logic          w_tmr_load, w_tmr_dec, w_tmr_zero;
  logic [TW-1:0] w_tmr_val, w_tmr_count;

  assign w_now = '{hour: bus.Hour_in,  min: bus.Min_in,  sec: bus.Sec_in};
  assign w_alm = '{hour: bus.Hour_alm, min: bus.Min_alm, sec: bus.Sec_alm};
  assign w_eq  = (w_now == w_alm);

  // r_low_seen blocks a match that was already present when reset released
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_match    <= 1'b0;
      r_low_seen <= 1'b0;
    end else if (bus.tick_1hz) begin
      r_match <= w_eq;
      if (!w_eq) r_low_seen <= 1'b1;
    end
  end

  assign w_trigger = bus.tick_1hz && w_eq && !r_match && r_low_seen;
  assign w_last    = w_tmr_zero || (w_tmr_count == TW'(1));

  sec_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_count    (w_tmr_count),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_music   <= 1'b0;
      r_snz_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_music   <= w_music_nxt;
      r_snz_cnt <= w_snz_cnt_nxt;
    end
  end

  // Next state; stop beats snooze, and any exit discards the coincident tick
  always_comb begin
    w_state_nxt   = r_state;
    w_music_nxt   = 1'b0;
    w_snz_cnt_nxt = r_snz_cnt;
    w_tmr_load    = 1'b0;
    w_tmr_val     = '0;
    w_tmr_dec     = 1'b0;
    if (!bus.alarm_en) begin
      w_state_nxt   = IDLE;
      w_snz_cnt_nxt = '0;
      w_tmr_load    = 1'b1;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = ARMED;
        ARMED: begin
          if (w_trigger) begin
            w_state_nxt   = RINGING;
            w_music_nxt   = 1'b1;
            w_snz_cnt_nxt = '0;
            w_tmr_load    = 1'b1;
            w_tmr_val     = TW'(RING_SECS);
          end
        end
        RINGING: begin
          if (bus.stop) begin
            w_state_nxt   = ARMED;
            w_snz_cnt_nxt = '0;
            w_tmr_load    = 1'b1;
          end else if (bus.snooze && (r_snz_cnt < CW'(MAX_SNOOZE))) begin
            w_state_nxt   = SNOOZE;
            w_snz_cnt_nxt = r_snz_cnt + CW'(1);
            w_tmr_load    = 1'b1;
            w_tmr_val     = TW'(SNOOZE_SECS);
          end else if (bus.tick_1hz && w_last) begin
            w_state_nxt   = ARMED;
            w_snz_cnt_nxt = '0;
            w_tmr_load    = 1'b1;
          end else begin
            w_music_nxt = bus.tick_1hz ? !r_music : r_music;
            w_tmr_dec   = bus.tick_1hz;
          end
        end
        SNOOZE: begin
          if (bus.stop) begin
            w_state_nxt   = ARMED;
            w_snz_cnt_nxt = '0;
            w_tmr_load    = 1'b1;
          end else if (bus.tick_1hz && w_last) begin
            w_state_nxt = RINGING;
            w_music_nxt = 1'b1;
            w_tmr_load  = 1'b1;
            w_tmr_val   = TW'(RING_SECS);
          end else begin
            w_tmr_dec = bus.tick_1hz;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign bus.music_out  = r_music;
  assign bus.state      = r_state;
  assign bus.snooze_cnt = r_snz_cnt;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: vector table plus long multi-cycle sequences.
module tb_alarm_ctrl;
  import clock_pkg::*;

  typedef struct {
    bit           tk;
    bit           st;
    bit           sn;
    bit           en;
    logic [6:0]   m;
    logic [6:0]   s;
    alarm_state_e est;
    bit           emus;
    logic [1:0]   ecnt;
  } vec_t;

  typedef struct {
    string        name;
    alarm_state_e st;
    bit           mus;
    logic [1:0]   cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  vec_t vecs[14];

  alarm_ctrl_if bus ();

  alarm_ctrl #(.RING_SECS(60), .SNOOZE_SECS(300), .MAX_SNOOZE(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: empty queue at t=%0t", $time);
      return;
    end
    e = sb_q.pop_front();
    checks++;
    if (bus.state !== e.st || bus.music_out !== e.mus || bus.snooze_cnt !== e.cnt) begin
      errors++;
      $display("FAIL %s: got state=%0d music=%0b cnt=%0d, want state=%0d music=%0b cnt=%0d",
               e.name, bus.state, bus.music_out, bus.snooze_cnt, e.st, e.mus, e.cnt);
    end
  endtask

  task automatic step(input string name, input bit tk, input bit st, input bit sn,
                      input bit en, input alarm_state_e est, input bit emus,
                      input logic [1:0] ecnt);
    @(negedge clk);
    bus.tick_1hz = tk;
    bus.stop     = st;
    bus.snooze   = sn;
    bus.alarm_en = en;
    sb_q.push_back('{name, est, emus, ecnt});
    @(posedge clk);
    #1;
    check_pop();
  endtask

  task automatic set_time(input logic [6:0] m, input logic [6:0] s);
    bus.Hour_in = 7'd7;
    bus.Min_in  = m;
    bus.Sec_in  = s;
  endtask

  // Drop the match for one tick, then restore it so a fresh edge fires
  task automatic trigger(input string name);
    set_time(7'd30, 7'd1);
    step({name, "_clear"}, 1, 0, 0, 1, ARMED, 0, 2'd0);
    set_time(7'd30, 7'd0);
    step({name, "_fire"}, 1, 0, 0, 1, RINGING, 1, 2'd0);
  endtask

  initial begin
    vecs[0]  = '{0, 0, 0, 1, 7'd29, 7'd59, ARMED,   0, 2'd0};
    vecs[1]  = '{1, 0, 0, 1, 7'd29, 7'd59, ARMED,   0, 2'd0};
    vecs[2]  = '{0, 0, 0, 1, 7'd30, 7'd0,  ARMED,   0, 2'd0};
    vecs[3]  = '{1, 0, 0, 1, 7'd30, 7'd0,  RINGING, 1, 2'd0};
    vecs[4]  = '{0, 0, 0, 1, 7'd30, 7'd0,  RINGING, 1, 2'd0};
    vecs[5]  = '{1, 0, 0, 1, 7'd30, 7'd0,  RINGING, 0, 2'd0};
    vecs[6]  = '{0, 0, 0, 1, 7'd30, 7'd0,  RINGING, 0, 2'd0};
    vecs[7]  = '{1, 0, 0, 1, 7'd30, 7'd0,  RINGING, 1, 2'd0};
    vecs[8]  = '{0, 0, 1, 1, 7'd30, 7'd0,  SNOOZE,  0, 2'd1};
    vecs[9]  = '{0, 1, 0, 1, 7'd30, 7'd0,  ARMED,   0, 2'd0};
    vecs[10] = '{1, 0, 0, 1, 7'd30, 7'd1,  ARMED,   0, 2'd0};
    vecs[11] = '{1, 0, 0, 1, 7'd30, 7'd0,  RINGING, 1, 2'd0};
    vecs[12] = '{0, 0, 1, 1, 7'd30, 7'd0,  SNOOZE,  0, 2'd1};
    vecs[13] = '{0, 0, 0, 0, 7'd30, 7'd0,  IDLE,    0, 2'd0};

    reset        = 1'b1;
    bus.tick_1hz = 1'b0;
    bus.stop     = 1'b0;
    bus.snooze   = 1'b0;
    bus.alarm_en = 1'b0;
    bus.Hour_alm = 7'd7;
    bus.Min_alm  = 7'd30;
    bus.Sec_alm  = 7'd0;
    set_time(7'd29, 7'd59);
    repeat (2) @(negedge clk);
    sb_q.push_back('{"reset", IDLE, 0, 2'd0});
    check_pop();
    reset = 1'b0;

    // Table: arm, trigger, toggle, snooze, stop from snooze, disarm
    for (int i = 0; i < 14; i++) begin
      set_time(vecs[i].m, vecs[i].s);
      step($sformatf("vec%0d", i), vecs[i].tk, vecs[i].st, vecs[i].sn, vecs[i].en,
           vecs[i].est, vecs[i].emus, vecs[i].ecnt);
    end

    // Unattended ring times out after 60 ticks; held match must not re-fire
    step("rearm", 0, 0, 0, 1, ARMED, 0, 2'd0);
    trigger("to");
    for (int i = 1; i <= 60; i++) begin
      if (i < 60) begin
        step($sformatf("ring_t%0d", i), 1, 0, 0, 1, RINGING, (i % 2) == 0, 2'd0);
        step($sformatf("ring_g%0d", i), 0, 0, 0, 1, RINGING, (i % 2) == 0, 2'd0);
      end else begin
        step("timeout", 1, 0, 0, 1, ARMED, 0, 2'd0);
        step("timeout_hold", 0, 0, 0, 1, ARMED, 0, 2'd0);
      end
    end
    for (int i = 0; i < 3; i++) step($sformatf("held%0d", i), 1, 0, 0, 1, ARMED, 0, 2'd0);

    // Three snoozes each re-ring after 300 ticks; the fourth is ignored
    trigger("snz");
    for (int k = 1; k <= 3; k++) begin
      step($sformatf("snooze%0d", k), k == 1, 0, 1, 1, SNOOZE, 0, 2'(k));
      for (int i = 1; i <= 300; i++) begin
        if (i < 300) begin
          step($sformatf("snz%0d_t%0d", k, i), 1, 0, 0, 1, SNOOZE, 0, 2'(k));
          step($sformatf("snz%0d_g%0d", k, i), 0, 0, 0, 1, SNOOZE, 0, 2'(k));
        end else begin
          step($sformatf("rering%0d", k), 1, 0, 0, 1, RINGING, 1, 2'(k));
          step($sformatf("rering%0d_hold", k), 0, 0, 0, 1, RINGING, 1, 2'(k));
        end
      end
    end
    step("snooze4_ignored", 0, 0, 1, 1, RINGING, 1, 2'd3);
    step("ring_continues", 1, 0, 0, 1, RINGING, 0, 2'd3);
    step("stop_and_snooze", 1, 1, 1, 1, ARMED, 0, 2'd0);

    // Reset mid-snooze while the time still equals the alarm
    trigger("rst");
    step("rst_snooze", 0, 0, 1, 1, SNOOZE, 0, 2'd1);
    step("rst_snooze_tick", 1, 0, 0, 1, SNOOZE, 0, 2'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    sb_q.push_back('{"async_reset", IDLE, 0, 2'd0});
    check_pop();
    @(negedge clk);
    reset = 1'b0;
    step("post_rst_arm", 0, 0, 0, 1, ARMED, 0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      step($sformatf("post_rst_t%0d", i), 1, 0, 0, 1, ARMED, 0, 2'd0);
      step($sformatf("post_rst_g%0d", i), 0, 0, 0, 1, ARMED, 0, 2'd0);
    end
    trigger("rearm");

    // Disarm while ringing
    step("disarm_ring", 0, 0, 0, 0, IDLE, 0, 2'd0);
    step("disarm_tick", 1, 0, 0, 0, IDLE, 0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
